hdc_class_trainer: RTL and testbench

//  Builds binary class prototypes (ham, spam) for the HDC spam classifier from labelled, already-encoded binary

---
 rtl/hdc_class_trainer_if.sv | 25 ++
 rtl/hdc_class_trainer.sv | 185 ++++++++++++++++++
 tb/tb_hdc_class_trainer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdc_class_trainer_if.sv
// Stream bundle for hdc_class_trainer: labelled message HV beats in, prototype beats out.
// The trainer connects through the slave modport; the traffic source/sink uses master.
interface hdc_class_trainer_if #(
    parameter int W = 32
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_label;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_class;
    logic         m_last;

    modport master (
        output s_valid, s_data, s_label, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_class, m_last
    );
    modport slave (
        input  s_valid, s_data, s_label, s_last, m_ready,
        output s_ready, m_valid, m_data, m_class, m_last
    );
endinterface

// File: rtl/hdc_class_trainer.sv
// HDC class trainer: accumulates per-dimension ham/spam counters, then majority-thresholds and streams both prototypes.
// Optional HDC_TRAINER_TIEBREAK_EN: ties (2*cnt == n, n>0) take their bit from a 16-bit Fibonacci LFSR.
module hdc_class_trainer #(
    parameter int DIM = 1024,
    parameter int W   = 32,
    parameter int CW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hdc_class_trainer_if.slave   bus,
    input  logic                 train_done,
    output logic [CW-1:0]        n_ham,
    output logic [CW-1:0]        n_spam,
    output logic                 err_len,
    output logic                 sat,
    output logic                 busy
);
    localparam int BEATS = DIM / W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] CMAX      = '1;

    typedef enum logic [1:0] {CLEAR, ACCUM, OUT} state_t;

    state_t         state, state_nxt;
    logic [BW-1:0]  beat, beat_nxt;
    logic [CW-1:0]  cnt   [2][DIM];
    logic [CW-1:0]  n_cnt [2];
    logic           lbl_q, drop_q, td_pend;
    logic           accept, cur_lbl, cur_drop;
    logic           out_cls, ld_cls, load, out_final;
    logic [BW-1:0]  out_beat, ld_beat;
    logic           m_valid_q, m_class_q, m_last_q;
    logic [W-1:0]   m_data_q, proto;
    logic [CW:0]    dbl, thr;
`ifdef HDC_TRAINER_TIEBREAK_EN
    localparam logic [15:0] SEED = 16'hACE1;
    logic [15:0]    lfsr, lfsr_nxt;
`endif

    function automatic logic [IW-1:0] dim_idx(input logic [BW-1:0] b, input int k);
        return IW'(int'(b) * W + k);
    endfunction

    // Label and drop decision are live on beat 0 and latched for the rest of the message.
    assign accept   = (state == ACCUM) && bus.s_valid;
    assign cur_lbl  = (beat == '0) ? bus.s_label : lbl_q;
    assign cur_drop = (beat == '0) ? (n_cnt[bus.s_label] == CMAX) : drop_q;

    assign out_final = (state == OUT) && m_valid_q && bus.m_ready && out_cls && (out_beat == LAST_BEAT);
    assign load      = (state == OUT) && (!m_valid_q || (bus.m_ready && !out_final));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        case (state)
            CLEAR: begin
                beat_nxt = beat + 1'b1;
                if (beat == LAST_BEAT) begin
                    beat_nxt  = '0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (accept)
                    beat_nxt = (bus.s_last || beat == LAST_BEAT) ? '0 : beat + 1'b1;
                if ((train_done || td_pend) && beat_nxt == '0)
                    state_nxt = OUT;
            end
            OUT:     if (out_final) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        ld_cls  = 1'b0;
        ld_beat = '0;
        if (m_valid_q) begin
            if (out_beat == LAST_BEAT) begin
                ld_cls  = 1'b1;
                ld_beat = '0;
            end else begin
                ld_cls  = out_cls;
                ld_beat = out_beat + 1'b1;
            end
        end
    end

    // Majority threshold for the beat about to be loaded; CW+1 bits hold 2*cnt without overflow.
    always_comb begin
        proto = '0;
        dbl   = '0;
        thr   = {1'b0, n_cnt[ld_cls]};
`ifdef HDC_TRAINER_TIEBREAK_EN
        lfsr_nxt = lfsr;
`endif
        for (int k = 0; k < W; k++) begin
            dbl      = {cnt[ld_cls][dim_idx(ld_beat, k)], 1'b0};
            proto[k] = (thr != '0) && (dbl > thr);
`ifdef HDC_TRAINER_TIEBREAK_EN
            if (thr != '0 && dbl == thr) proto[k] = lfsr_nxt[15];
            lfsr_nxt = {lfsr_nxt[14:0], lfsr_nxt[15] ^ lfsr_nxt[13] ^ lfsr_nxt[12] ^ lfsr_nxt[10]};
`endif
        end
    end

    // NOTE: the counter array has no reset; CLEAR rewrites every entry before ACCUM can read it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            for (int k = 0; k < W; k++) begin
                cnt[0][dim_idx(beat, k)] <= '0;
                cnt[1][dim_idx(beat, k)] <= '0;
            end
        end else if (accept && !cur_drop) begin
            for (int k = 0; k < W; k++)
                if (bus.s_data[k] && cnt[cur_lbl][dim_idx(beat, k)] != CMAX)
                    cnt[cur_lbl][dim_idx(beat, k)] <= cnt[cur_lbl][dim_idx(beat, k)] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            beat      <= '0;
            lbl_q     <= 1'b0;
            drop_q    <= 1'b0;
            td_pend   <= 1'b0;
            n_cnt     <= '{default: '0};
            err_len   <= 1'b0;
            sat       <= 1'b0;
            out_cls   <= 1'b0;
            out_beat  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_class_q <= 1'b0;
            m_last_q  <= 1'b0;
`ifdef HDC_TRAINER_TIEBREAK_EN
            lfsr      <= SEED;
`endif
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            if (accept) begin
                if (beat == '0) begin
                    lbl_q  <= bus.s_label;
                    drop_q <= cur_drop;
                    if (cur_drop) sat <= 1'b1;
                end
                if (bus.s_last != (beat == LAST_BEAT))
                    err_len <= 1'b1;
                else if (bus.s_last && !cur_drop)
                    n_cnt[cur_lbl] <= n_cnt[cur_lbl] + 1'b1;
            end
            td_pend <= (state == ACCUM) && (train_done || td_pend) && (state_nxt != OUT);
`ifdef HDC_TRAINER_TIEBREAK_EN
            if (state == ACCUM && state_nxt == OUT) lfsr <= SEED;
            if (load) lfsr <= lfsr_nxt;
`endif
            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= proto;
                m_class_q <= ld_cls;
                m_last_q  <= (ld_beat == LAST_BEAT);
                out_cls   <= ld_cls;
                out_beat  <= ld_beat;
            end else if (out_final) begin
                m_valid_q <= 1'b0;
                n_cnt     <= '{default: '0};
                err_len   <= 1'b0;
                sat       <= 1'b0;
            end
        end
    end

    assign bus.s_ready = (state == ACCUM);
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_class = m_class_q;
    assign bus.m_last  = m_last_q;
    assign busy        = (state != ACCUM);
    assign n_ham       = n_cnt[0];
    assign n_spam      = n_cnt[1];
endmodule

// File: tb/tb_hdc_class_trainer.sv
// Scoreboard bench for hdc_class_trainer (DIM=1024, W=32, CW=4, tie-break disabled).
// Stimulus pushes expected prototype beats; a monitor pops and compares on every output handshake.
module tb_hdc_class_trainer;
    localparam int DIM   = 1024;
    localparam int W     = 32;
    localparam int CW    = 4;
    localparam int BEATS = DIM / W;

    typedef logic [W-1:0] hv_t [BEATS];
    typedef struct packed {
        logic [W-1:0] data;
        logic         cls;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          train_done = 1'b0;
    logic [CW-1:0] n_ham, n_spam;
    logic          err_len, sat, busy;
    bit            ready_toggle = 1'b0;
    beat_t         exp_q [$];
    int            n_checks = 0;
    int            n_fail = 0;

    hdc_class_trainer_if #(.W(W)) bus ();

    hdc_class_trainer #(.DIM(DIM), .W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .train_done (train_done),
        .n_ham      (n_ham),
        .n_spam     (n_spam),
        .err_len    (err_len),
        .sat        (sat),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // m_ready changes just after the rising edge so negedge samples see a settled value.
    initial begin : ready_driver
        int cyc = 0;
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.m_ready = ready_toggle ? (cyc % 3 != 1) : 1'b1;
        end
    end

    initial begin : monitor
        beat_t held, want, got;
        bit    holding = 1'b0;
        forever begin
            @(negedge clk);
            got = {bus.m_data, bus.m_class, bus.m_last};
            if (holding) begin
                check("hold_valid", 64'(bus.m_valid), 1);
                check("hold_beat", 64'(got), 64'(held));
            end
            holding = bus.m_valid && !bus.m_ready;
            held    = got;
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    want = exp_q.pop_front();
                    check("beat_data", 64'(got.data), 64'(want.data));
                    check("beat_class", 64'(got.cls), 64'(want.cls));
                    check("beat_last", 64'(got.last), 64'(want.last));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic hv_t fill(input logic [W-1:0] v);
        hv_t h;
        for (int b = 0; b < BEATS; b++) h[b] = v;
        return h;
    endfunction

    task automatic push_proto(input logic cls, input hv_t h);
        for (int b = 0; b < BEATS; b++) exp_q.push_back({h[b], cls, (b == BEATS - 1)});
    endtask

    // Sends nbeats beats; s_last on beat last_at; optional train_done on the final beat.
    task automatic send_msg(input logic lbl, input hv_t h, input int nbeats, input int last_at, input bit td_last);
        for (int b = 0; b < nbeats; b++) begin
            int guard = 0;
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = h[b];
            bus.s_label = lbl;
            bus.s_last  = (b == last_at);
            train_done  = td_last && (b == nbeats - 1);
            while (!bus.s_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!bus.s_ready) begin
                check("send_timeout", 0, 1);
                bus.s_valid = 1'b0;
                train_done  = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        train_done  = 1'b0;
    endtask

    task automatic pulse_train();
        @(negedge clk);
        train_done = 1'b1;
        @(negedge clk);
        train_done = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_remaining", 64'(exp_q.size()), 0);
        repeat (2) @(negedge clk);
        check("m_valid_after_out", 64'(bus.m_valid), 0);
        check("busy_after_out", 64'(busy), 1);
        check("n_ham_cleared", 64'(n_ham), 0);
        check("n_spam_cleared", 64'(n_spam), 0);
        check("err_len_cleared", 64'(err_len), 0);
        check("sat_cleared", 64'(sat), 0);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!bus.s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_after_clear", 64'(bus.s_ready), 1);
        check("busy_after_clear", 64'(busy), 0);
    endtask

    task automatic do_reset();
        int low = 0;
        @(negedge clk);
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        train_done  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", 64'(bus.s_ready), 0);
        check("rst_m_valid", 64'(bus.m_valid), 0);
        check("rst_m_data", 64'(bus.m_data), 0);
        check("rst_m_class", 64'(bus.m_class), 0);
        check("rst_m_last", 64'(bus.m_last), 0);
        check("rst_n_ham", 64'(n_ham), 0);
        check("rst_n_spam", 64'(n_spam), 0);
        check("rst_err_len", 64'(err_len), 0);
        check("rst_sat", 64'(sat), 0);
        check("rst_busy", 64'(busy), 1);
        rst_n = 1'b1;
        while (!bus.s_ready && low < 100) begin
            low++;
            @(negedge clk);
        end
        check("clear_cycles", 64'(low), BEATS);
        check("busy_falls_with_ready", 64'(busy), 0);
    endtask

    initial begin : main
        hv_t ones, zeros, pat, part, spam_exp;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_label = 1'b0;
        bus.s_last  = 1'b0;
        ones  = fill('1);
        zeros = fill('0);

        // Reset values and CLEAR length.
        do_reset();

        // Ham all-1, all-0, all-1: ham prototype all ones, spam (n=0) all zeros.
        send_msg(1'b0, ones, BEATS, BEATS - 1, 1'b0);
        send_msg(1'b0, zeros, BEATS, BEATS - 1, 1'b0);
        send_msg(1'b0, ones, BEATS, BEATS - 1, 1'b0);
        check("n_ham_three", 64'(n_ham), 3);
        check("n_spam_zero", 64'(n_spam), 0);
        check("err_len_clean", 64'(err_len), 0);
        push_proto(1'b0, ones);
        push_proto(1'b1, zeros);
        pulse_train();
        wait_drain();
        wait_ready();

        // Tie on ham; early s_last on spam; partial sums kept; m_ready toggling.
        send_msg(1'b0, ones, BEATS, BEATS - 1, 1'b0);
        send_msg(1'b0, zeros, BEATS, BEATS - 1, 1'b0);
        check("n_ham_two", 64'(n_ham), 2);
        part = fill(32'h0000_FFFF);
        send_msg(1'b1, part, 6, 5, 1'b0);
        check("err_len_early_last", 64'(err_len), 1);
        check("n_spam_after_short", 64'(n_spam), 0);
        for (int b = 0; b < BEATS; b++) pat[b] = 32'h1234_5678 ^ {4{8'(b * 37)}};
        send_msg(1'b1, pat, BEATS, BEATS - 1, 1'b0);
        check("n_spam_after_full", 64'(n_spam), 1);
        check("n_ham_kept", 64'(n_ham), 2);
        for (int b = 0; b < BEATS; b++) spam_exp[b] = (b < 6) ? (pat[b] | 32'h0000_FFFF) : pat[b];
        push_proto(1'b0, zeros);
        push_proto(1'b1, spam_exp);
        ready_toggle = 1'b1;
        pulse_train();
        wait_drain();
        ready_toggle = 1'b0;
        wait_ready();

        // Reset mid-message must restart at beat 0.
        send_msg(1'b1, ones, 3, -1, 1'b0);
        do_reset();

        // Saturation: 7 x all-ones, 8 x FFFF0000 counted; 16th all-ones dropped, train_done with its last beat.
        for (int i = 0; i < 15; i++)
            send_msg(1'b1, (i < 7) ? ones : fill(32'hFFFF_0000), BEATS, BEATS - 1, 1'b0);
        check("sat_before_drop", 64'(sat), 0);
        push_proto(1'b0, zeros);
        push_proto(1'b1, fill(32'hFFFF_0000));
        send_msg(1'b1, ones, BEATS, BEATS - 1, 1'b1);
        check("n_spam_saturated", 64'(n_spam), 15);
        check("sat_set", 64'(sat), 1);
        check("err_len_sat_clean", 64'(err_len), 0);
        check("out_after_final_beat", 64'(bus.s_ready), 0);
        wait_drain();
        wait_ready();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
